func_xs: RTL and testbench
==========================

Name: func_xs

Overview:
- Kuznechik round front half: X (128-bit round-key XOR) followed by S (bytewise nonlinear substitution Pi).
- Output feeds funcL directly. Chain per round is X → S → L.
- Streaming pipeline; accepts one block per cycle with a put/ready valid flag matching funcL's handshake, so res/ready connect straight to funcL data/put.

Parameters:
- REG_XOR, 1: 1 = X result registered in its own stage (latency 2); 0 = X and S combined in a single stage (latency 1).
- BYPASS_X, 0: 1 = key input ignored, block performs S only (for standalone S testing).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- put  in  1  input block valid this cycle
- data  in  128  input block
- key  in  128  round key, sampled in the same cycle as data
- res  out  128  substituted block
- ready  out  1  res valid this cycle

Behaviour:
- Reset is asynchronous, active-low: all pipeline data registers clear to 0, all valid flags clear to 0. While rst_n is low, res = 0 and ready = 0.
- Byte lanes: lane i = bits [8i+7:8i], i = 0..15. Lanes are independent.
- X stage: x = data ^ key, or x = data when BYPASS_X = 1.
- S stage: res lane i = PI[x lane i], using the 256-entry GOST R 34.12-2015 Pi table. For example, PI[00] = fc and PI[ff] = b6.
- Latency, REG_XOR = 1:
  - Stage 1 registers x and v1 <= put.
  - Stage 2 registers PI(x) and ready <= v1.
  - A put at edge n gives ready = 1 with a valid res after edge n+2.
- Latency, REG_XOR = 0: one register stage; ready follows put by 1 cycle.
- Throughput: one block per cycle. No back-pressure. Any put/gap pattern is reproduced exactly at ready, delayed by the latency.
- Data registers:
  - Load on every cycle where the corresponding valid bit is 1.
  - Hold their previous value when the valid bit is 0.
  - res therefore holds the last valid result while ready = 0. Consumers must qualify with ready.
- Key: no key storage. key is consumed only in the cycle put = 1, and may change every cycle (per-block keys).
- Reset mid-stream: all in-flight blocks are dropped, ready drops to 0 immediately (asynchronous), and no stale ready appears after rst_n releases.
- put asserted on the first edge after rst_n release: accepted normally.
- X/unknown on data while put = 0: must not propagate to res.

Decomposition:
- Shared package kuz_pkg:
  - PI table as a 256×8 constant array, plus PI_INV (for the future decryption S stage).
  - BLOCK_W = 128, BYTE_W = 8, N_LANES = 16.
- Sub-module sbox8: combinational 8-bit lookup from kuz_pkg PI, instantiated 16× with generate.
- The pipeline and valid chain stay in func_xs.

Test Plan:
- GOST S vector, BYPASS_X = 1: put data = ffeeddccbbaa99881122334455667700 → ready after 2 cycles, res = b66cd8887d38e8d77765aeea0c9a7efc.
- Back-to-back GOST chain, BYPASS_X = 1: apply the three inputs below on consecutive cycles → ready high 3 cycles, with these outputs in order:
  - b66cd8887d38e8d77765aeea0c9a7efc → 559d8dd7bd06cbfe7e7b262523280d39
  - 559d8dd7bd06cbfe7e7b262523280d39 → 0c3322fed531e4630d80ef5c5a81c50b
  - 0c3322fed531e4630d80ef5c5a81c50b → 23ae65633f842d29c5df529c13f5acda
- X+S corners: key = data = 0 → res = fcfc…fc (16 bytes). data = 0 with key = all-ones → res = b6b6…b6.
- Gapped stream put = 1,0,1,1,0: ready = 1,0,1,1,0 delayed by 2 cycles. res holds the previous value during gaps.
- Reset mid-stream: pull rst_n low with 2 blocks in flight → ready and res go to 0 at once. After release with put = 0, ready stays 0 for ≥ 3 cycles.
- Integration: func_xs → funcL → compare the first GOST round output against a software model for 20 random blocks and keys at full rate (total latency 2 + funcL's 16).

Source files
------------

// File: rtl/kuz_pkg.sv
// Shared Kuznechik constants: block geometry and the GOST R 34.12-2015 Pi substitution.
package kuz_pkg;

   localparam int BLOCK_W = 128;
   localparam int BYTE_W  = 8;
   localparam int N_LANES = 16;

   localparam logic [7:0] PI [256] = '{
      8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
      8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
      8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
      8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
      8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
      8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
      8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
      8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
      8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
      8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
      8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
      8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
      8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
      8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
      8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
      8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
   };

   // Inverse substitution for the decryption S stage, derived from PI so the two can never disagree.
   function automatic logic [7:0] pi_inv(input logic [7:0] y);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 256; i++) begin
         if (PI[i] == y) r = 8'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/sbox8.sv
// One byte lane of the S transform: combinational Pi lookup.
module sbox8
   import kuz_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   output logic [BYTE_W-1:0] y
);

   assign y = PI[a];

endmodule

// File: rtl/func_xs.sv
// Kuznechik round front half: X (key XOR) then S (bytewise Pi), streaming with put/ready.
module func_xs
   import kuz_pkg::*;
#(
   parameter bit REG_XOR  = 1'b1,
   parameter bit BYPASS_X = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               put,
   input  logic [BLOCK_W-1:0] data,
   input  logic [BLOCK_W-1:0] key,
   output logic [BLOCK_W-1:0] res,
   output logic               ready
);

   logic [BLOCK_W-1:0] x_p0;
   logic [BLOCK_W-1:0] s_in;
   logic               s_vld;
   logic [BLOCK_W-1:0] s_out;
   logic [BLOCK_W-1:0] res_p2;
   logic               vld_p2;

   assign x_p0 = BYPASS_X ? data : (data ^ key);

   // X stage register (optional): isolates the XOR from the S-box depth
   if (REG_XOR) begin : g_reg_x
      logic [BLOCK_W-1:0] x_p1;
      logic               vld_p1;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            x_p1   <= '0;
            vld_p1 <= 1'b0;
         end else begin
            vld_p1 <= put;
            if (put) x_p1 <= x_p0;
         end
      end

      assign s_in  = x_p1;
      assign s_vld = vld_p1;
   end else begin : g_comb_x
      assign s_in  = x_p0;
      assign s_vld = put;
   end

   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      sbox8 u_sbox (
         .a (s_in [i*BYTE_W +: BYTE_W]),
         .y (s_out[i*BYTE_W +: BYTE_W])
      );
   end

   // S stage register: loads only with a valid block so res holds across gaps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_p2 <= '0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p2 <= s_vld;
         if (s_vld) res_p2 <= s_out;
      end
   end

   assign res   = res_p2;
   assign ready = vld_p2;

endmodule

// File: tb/tb_func_xs.sv
// Scoreboard bench for func_xs: two instances (registered X with key, combined stage with X bypassed).
module tb_func_xs;
   import kuz_pkg::*;

   typedef struct {
      logic [127:0] val;
      int           due;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         put;
   logic [127:0] data;
   logic [127:0] key;
   logic [127:0] res0, res1;
   logic         ready0, ready1;
   logic [127:0] res_a [2];
   logic         ready_a [2];

   int   cyc;
   int   errors;
   int   checks;
   exp_t q [2][$];
   logic [127:0] held [2];

   func_xs #(.REG_XOR(1'b1), .BYPASS_X(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .put(put), .data(data), .key(key), .res(res0), .ready(ready0)
   );

   func_xs #(.REG_XOR(1'b0), .BYPASS_X(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .put(put), .data(data), .key(key), .res(res1), .ready(ready1)
   );

   assign res_a[0]   = res0;
   assign res_a[1]   = res1;
   assign ready_a[0] = ready0;
   assign ready_a[1] = ready1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   // Reference S transform: bytewise Pi lookup on the whole block.
   function automatic logic [127:0] s_ref(input logic [127:0] x);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = PI[x[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Drive one cycle; a valid block pushes each instance's expected result and due cycle.
   task automatic issue(input logic p, input logic [127:0] d, input logic [127:0] k,
                        input logic [127:0] e0, input logic [127:0] e1);
      exp_t e;
      @(negedge clk);
      put  = p;
      data = d;
      key  = k;
      if (p) begin
         e.val = e0; e.due = cyc + 2; q[0].push_back(e);
         e.val = e1; e.due = cyc + 1; q[1].push_back(e);
      end
   endtask

   task automatic issue_model(input logic [127:0] d, input logic [127:0] k);
      issue(1'b1, d, k, s_ref(d ^ k), s_ref(d));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(1'b0, rand128(), rand128(), '0, '0);
   endtask

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      checks = checks + 1;
      if (got !== want) begin
         errors = errors + 1;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Monitor: pops and compares whenever an instance presents ready.
   initial begin
      exp_t e;
      held[0] = '0;
      held[1] = '0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
               chk($sformatf("dut%0d reset res", k), res_a[k], '0);
               chk($sformatf("dut%0d reset ready", k), {127'b0, ready_a[k]}, '0);
               q[k].delete();
               held[k] = '0;
            end else if (ready_a[k]) begin
               if (q[k].size() == 0) begin
                  chk($sformatf("dut%0d spurious ready", k), {127'b0, ready_a[k]}, '0);
               end else begin
                  e = q[k].pop_front();
                  chk($sformatf("dut%0d res", k), res_a[k], e.val);
                  chk($sformatf("dut%0d latency cycle", k), 128'(cyc), 128'(e.due));
                  held[k] = e.val;
               end
            end else begin
               chk($sformatf("dut%0d hold res", k), res_a[k], held[k]);
               if (q[k].size() > 0 && q[k][0].due <= cyc) begin
                  e = q[k].pop_front();
                  chk($sformatf("dut%0d missing ready", k), {127'b0, ready_a[k]}, 128'd1);
               end
            end
         end
      end
   end

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      put    = 1'b0;
      data   = '0;
      key    = '0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // GOST S vector, accepted on the first edge after reset release
      issue(1'b1, 128'hffeeddccbbaa99881122334455667700, '0,
            128'hb66cd8887d38e8d77765aeea0c9a7efc, 128'hb66cd8887d38e8d77765aeea0c9a7efc);
      idle(3);

      // Back-to-back GOST chain
      issue(1'b1, 128'hb66cd8887d38e8d77765aeea0c9a7efc, '0,
            128'h559d8dd7bd06cbfe7e7b262523280d39, 128'h559d8dd7bd06cbfe7e7b262523280d39);
      issue(1'b1, 128'h559d8dd7bd06cbfe7e7b262523280d39, '0,
            128'h0c3322fed531e4630d80ef5c5a81c50b, 128'h0c3322fed531e4630d80ef5c5a81c50b);
      issue(1'b1, 128'h0c3322fed531e4630d80ef5c5a81c50b, '0,
            128'h23ae65633f842d29c5df529c13f5acda, 128'h23ae65633f842d29c5df529c13f5acda);
      idle(3);

      // X+S corners; the bypass instance ignores the all-ones key
      issue(1'b1, '0, '0, {16{8'hfc}}, {16{8'hfc}});
      issue(1'b1, '0, '1, {16{8'hb6}}, {16{8'hfc}});
      idle(3);

      // Gapped stream 1,0,1,1,0
      issue_model(rand128(), rand128());
      idle(1);
      issue_model(rand128(), rand128());
      issue_model(rand128(), rand128());
      idle(3);

      // Full-rate random blocks with per-block keys
      for (int i = 0; i < 20; i++) issue_model(rand128(), rand128());
      idle(1);

      // Random put/gap pattern
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1) issue_model(rand128(), rand128());
         else idle(1);
      end
      idle(3);

      // Reset mid-stream with blocks in flight
      issue_model(rand128(), rand128());
      issue_model(rand128(), rand128());
      @(posedge clk);
      #2 rst_n = 1'b0;
      put = 1'b0;
      #1;
      chk("async reset ready0", {127'b0, ready0}, '0);
      chk("async reset res0", res0, '0);
      chk("async reset ready1", {127'b0, ready1}, '0);
      chk("async reset res1", res1, '0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         idle(1);
         #1;
         chk("post-reset ready0 idle", {127'b0, ready0}, '0);
         chk("post-reset ready1 idle", {127'b0, ready1}, '0);
      end

      // Stream resumes cleanly after reset
      for (int i = 0; i < 6; i++) issue_model(rand128(), rand128());
      idle(4);

      chk("dut0 scoreboard drained", 128'(q[0].size()), '0);
      chk("dut1 scoreboard drained", 128'(q[1].size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
